// File: rtl/time_of_day_counter.sv
// BCD hh:mm:ss time-of-day counter stepped by rising edges of a synchronized
// time-base level, with set-minutes, set-hours and pause/clear-seconds modes.
// Optional macro HOUR12_EN selects 12-hour display with AM/PM indicator;
// without it the counter runs 00..23 and pm is tied low.
module time_of_day_counter #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick_in,
   input  logic [1:0] mode,
   output logic [3:0] sec_ones,
   output logic [2:0] sec_tens,
   output logic [3:0] min_ones,
   output logic [2:0] min_tens,
   output logic [3:0] hr_ones,
   output logic [1:0] hr_tens,
   output logic       min_tick,
   output logic       day_wrap,
   output logic       pm
);

   localparam logic [1:0] MODE_RUN     = 2'd0;
   localparam logic [1:0] MODE_SET_MIN = 2'd1;
   localparam logic [1:0] MODE_SET_HR  = 2'd2;
   localparam logic [1:0] MODE_PAUSE   = 2'd3;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;
   logic [3:0]             sec_ones_q, sec_ones_d;
   logic [2:0]             sec_tens_q, sec_tens_d;
   logic [3:0]             min_ones_q, min_ones_d;
   logic [2:0]             min_tens_q, min_tens_d;
   logic [3:0]             hr_ones_q, hr_ones_d;
   logic [1:0]             hr_tens_q, hr_tens_d;
   logic                   min_tick_q, min_tick_d;
   logic                   day_wrap_q, day_wrap_d;

   logic                   step_c;
   logic [3:0]             min_inc_ones_c;
   logic [2:0]             min_inc_tens_c;
   logic                   min_wrap_c;
   logic [3:0]             hr_inc_ones_c;
   logic [1:0]             hr_inc_tens_c;
   logic                   hr_day_end_c;
`ifdef HOUR12_EN
   logic                   pm_q, pm_d;
   logic                   hr_pm_flip_c;
`endif

   assign step_c = sync_q[SYNC_STAGES-1] & ~prev_q;

   // Minutes +1 mod 60 in BCD, flagging the 59 -> 00 wrap
   always_comb begin
      min_inc_ones_c = min_ones_q + 4'd1;
      min_inc_tens_c = min_tens_q;
      min_wrap_c     = 1'b0;
      if (min_ones_q == 4'd9) begin
         min_inc_ones_c = 4'd0;
         if (min_tens_q == 3'd5) begin
            min_inc_tens_c = 3'd0;
            min_wrap_c     = 1'b1;
         end else begin
            min_inc_tens_c = min_tens_q + 3'd1;
         end
      end
   end

   // Hours +1 in the selected display format, flagging the end of the day
   always_comb begin
      hr_inc_ones_c = hr_ones_q + 4'd1;
      hr_inc_tens_c = hr_tens_q;
      hr_day_end_c  = 1'b0;
`ifdef HOUR12_EN
      hr_pm_flip_c  = 1'b0;
      if (hr_tens_q == 2'd1 && hr_ones_q == 4'd2) begin
         hr_inc_tens_c = 2'd0;
         hr_inc_ones_c = 4'd1;
      end else if (hr_tens_q == 2'd1 && hr_ones_q == 4'd1) begin
         // 11 -> 12 flips AM/PM; leaving 11 PM is the end of the day
         hr_inc_ones_c = 4'd2;
         hr_pm_flip_c  = 1'b1;
         hr_day_end_c  = pm_q;
      end else if (hr_ones_q == 4'd9) begin
         hr_inc_ones_c = 4'd0;
         hr_inc_tens_c = hr_tens_q + 2'd1;
      end
`else
      if (hr_tens_q == 2'd2 && hr_ones_q == 4'd3) begin
         hr_inc_tens_c = 2'd0;
         hr_inc_ones_c = 4'd0;
         hr_day_end_c  = 1'b1;
      end else if (hr_ones_q == 4'd9) begin
         hr_inc_ones_c = 4'd0;
         hr_inc_tens_c = hr_tens_q + 2'd1;
      end
`endif
   end

   // Next-state: synchronizer shift, mode-dependent digit update, pulses
   always_comb begin
      sync_d     = {sync_q[SYNC_STAGES-2:0], tick_in};
      prev_d     = sync_q[SYNC_STAGES-1];
      sec_ones_d = sec_ones_q;
      sec_tens_d = sec_tens_q;
      min_ones_d = min_ones_q;
      min_tens_d = min_tens_q;
      hr_ones_d  = hr_ones_q;
      hr_tens_d  = hr_tens_q;
      min_tick_d = 1'b0;
      day_wrap_d = 1'b0;
`ifdef HOUR12_EN
      pm_d       = pm_q;
`endif
      case (mode)
         MODE_RUN: begin
            if (step_c) begin
               if (sec_ones_q != 4'd9) begin
                  sec_ones_d = sec_ones_q + 4'd1;
               end else begin
                  sec_ones_d = 4'd0;
                  if (sec_tens_q != 3'd5) begin
                     sec_tens_d = sec_tens_q + 3'd1;
                  end else begin
                     sec_tens_d = 3'd0;
                     min_tick_d = 1'b1;
                     min_ones_d = min_inc_ones_c;
                     min_tens_d = min_inc_tens_c;
                     if (min_wrap_c) begin
                        hr_ones_d  = hr_inc_ones_c;
                        hr_tens_d  = hr_inc_tens_c;
                        day_wrap_d = hr_day_end_c;
`ifdef HOUR12_EN
                        pm_d       = pm_q ^ hr_pm_flip_c;
`endif
                     end
                  end
               end
            end
         end
         MODE_SET_MIN: begin
            if (step_c) begin
               min_ones_d = min_inc_ones_c;
               min_tens_d = min_inc_tens_c;
            end
         end
         MODE_SET_HR: begin
            if (step_c) begin
               hr_ones_d = hr_inc_ones_c;
               hr_tens_d = hr_inc_tens_c;
`ifdef HOUR12_EN
               pm_d      = pm_q ^ hr_pm_flip_c;
`endif
            end
         end
         MODE_PAUSE: begin
            sec_ones_d = 4'd0;
            sec_tens_d = 3'd0;
         end
      endcase
   end

   // State register with synchronous reset to start of day
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q     <= '0;
         prev_q     <= 1'b0;
         sec_ones_q <= 4'd0;
         sec_tens_q <= 3'd0;
         min_ones_q <= 4'd0;
         min_tens_q <= 3'd0;
         min_tick_q <= 1'b0;
         day_wrap_q <= 1'b0;
`ifdef HOUR12_EN
         hr_ones_q  <= 4'd2;
         hr_tens_q  <= 2'd1;
         pm_q       <= 1'b0;
`else
         hr_ones_q  <= 4'd0;
         hr_tens_q  <= 2'd0;
`endif
      end else begin
         sync_q     <= sync_d;
         prev_q     <= prev_d;
         sec_ones_q <= sec_ones_d;
         sec_tens_q <= sec_tens_d;
         min_ones_q <= min_ones_d;
         min_tens_q <= min_tens_d;
         hr_ones_q  <= hr_ones_d;
         hr_tens_q  <= hr_tens_d;
         min_tick_q <= min_tick_d;
         day_wrap_q <= day_wrap_d;
`ifdef HOUR12_EN
         pm_q       <= pm_d;
`endif
      end
   end

   assign sec_ones = sec_ones_q;
   assign sec_tens = sec_tens_q;
   assign min_ones = min_ones_q;
   assign min_tens = min_tens_q;
   assign hr_ones  = hr_ones_q;
   assign hr_tens  = hr_tens_q;
   assign min_tick = min_tick_q;
   assign day_wrap = day_wrap_q;
`ifdef HOUR12_EN
   assign pm       = pm_q;
`else
   assign pm       = 1'b0;
`endif

endmodule

// File: tb/tb_time_of_day_counter.sv
// Bench for time_of_day_counter: directed scenarios plus randomized tick/mode
// traffic, every cycle compared against a seconds-of-day reference model.
module tb_time_of_day_counter;

   localparam int S = 2;

   logic       clk;
   logic       reset;
   logic       tick_in;
   logic [1:0] mode;
   logic [3:0] sec_ones;
   logic [2:0] sec_tens;
   logic [3:0] min_ones;
   logic [2:0] min_tens;
   logic [3:0] hr_ones;
   logic [1:0] hr_tens;
   logic       min_tick;
   logic       day_wrap;
   logic       pm;

   int checks   = 0;
   int failures = 0;

   // Reference model: 24-hour h/m/s, pulse flags, tick_in sample history
   int m_h, m_m, m_s;
   bit m_mt, m_dw;
   bit hist [0:5];

   time_of_day_counter #(.SYNC_STAGES(S)) dut (
      .clk      (clk),
      .reset    (reset),
      .tick_in  (tick_in),
      .mode     (mode),
      .sec_ones (sec_ones),
      .sec_tens (sec_tens),
      .min_ones (min_ones),
      .min_tens (min_tens),
      .hr_ones  (hr_ones),
      .hr_tens  (hr_tens),
      .min_tick (min_tick),
      .day_wrap (day_wrap),
      .pm       (pm)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Advance the model by one clock edge with the inputs that edge samples
   task automatic model_edge(input bit rst, input bit tk, input logic [1:0] md);
      bit step;
      int total;
      if (rst) begin
         m_h = 0; m_m = 0; m_s = 0; m_mt = 0; m_dw = 0;
         for (int j = 0; j < 6; j++) hist[j] = 1'b0;
         return;
      end
      for (int j = 5; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = tk;
      // a rise sampled S edges ago is the step acted on now
      step = hist[S] && !hist[S+1];
      m_mt = 0; m_dw = 0;
      case (md)
         2'd0: if (step) begin
            m_mt  = (m_s == 59);
            total = m_h * 3600 + m_m * 60 + m_s + 1;
            if (total == 86400) begin
               total = 0;
               m_dw  = 1;
            end
            m_h = total / 3600;
            m_m = (total / 60) % 60;
            m_s = total % 60;
         end
         2'd1: if (step) m_m = (m_m + 1) % 60;
         2'd2: if (step) m_h = (m_h + 1) % 24;
         default: m_s = 0;
      endcase
   endtask

   task automatic check_all();
      int hd;
      int pmx;
      hd  = m_h;
      pmx = 0;
`ifdef HOUR12_EN
      hd  = (m_h % 12 == 0) ? 12 : m_h % 12;
      pmx = (m_h >= 12) ? 1 : 0;
`endif
      chk("sec_ones", 32'(sec_ones), 32'(m_s % 10));
      chk("sec_tens", 32'(sec_tens), 32'(m_s / 10));
      chk("min_ones", 32'(min_ones), 32'(m_m % 10));
      chk("min_tens", 32'(min_tens), 32'(m_m / 10));
      chk("hr_ones",  32'(hr_ones),  32'(hd % 10));
      chk("hr_tens",  32'(hr_tens),  32'(hd / 10));
      chk("min_tick", 32'(min_tick), 32'(m_mt));
      chk("day_wrap", 32'(day_wrap), 32'(m_dw));
      chk("pm",       32'(pm),       32'(pmx));
   endtask

   // One clock cycle: drive on negedge, model on posedge, compare 1 time unit later
   task automatic cyc(input bit rst, input bit tk, input logic [1:0] md);
      @(negedge clk);
      reset   = rst;
      tick_in = tk;
      mode    = md;
      @(posedge clk);
      model_edge(rst, tk, md);
      #1;
      check_all();
   endtask

   // n complete tick_in pulses, each phase S+1 cycles long
   task automatic ticks(input logic [1:0] md, input int n);
      for (int k = 0; k < n; k++) begin
         for (int i = 0; i <= S; i++) cyc(1'b0, 1'b1, md);
         for (int i = 0; i <= S; i++) cyc(1'b0, 1'b0, md);
      end
   endtask

   // One tick with explicit pulse checks on the update cycle and the one after
   task automatic tick_probe(input string tag, input logic [1:0] md,
                             input bit exp_mt, input bit exp_dw);
      for (int i = 0; i <= S + 1; i++) begin
         cyc(1'b0, 1'b1, md);
         if (i == S) begin
            chk({tag, "_min_tick"}, 32'(min_tick), 32'(exp_mt));
            chk({tag, "_day_wrap"}, 32'(day_wrap), 32'(exp_dw));
         end else if (i == S + 1) begin
            chk({tag, "_min_tick_drop"}, 32'(min_tick), 32'd0);
            chk({tag, "_day_wrap_drop"}, 32'(day_wrap), 32'd0);
         end
      end
      for (int i = 0; i <= S; i++) cyc(1'b0, 1'b0, md);
   endtask

   initial begin
      int len;
      int r;
      bit tk;
      logic [1:0] md;
      reset = 1'b1; tick_in = 1'b0; mode = 2'd0;
      m_h = 0; m_m = 0; m_s = 0;
      cyc(1'b1, 1'b0, 2'd0);
      cyc(1'b1, 1'b0, 2'd0);
      cyc(1'b0, 1'b0, 2'd0);

      // Preset 05:42:17, then reset mid-count
      ticks(2'd0, 17);
      ticks(2'd1, 42);
      ticks(2'd2, 5);
      chk("pre_min_tens", 32'(min_tens), 32'd4);
      cyc(1'b1, 1'b0, 2'd0);
      chk("rst_sec", 32'({sec_tens, sec_ones}), 32'd0);
      chk("rst_min", 32'({min_tens, min_ones}), 32'd0);
      chk("rst_pulse", 32'({min_tick, day_wrap}), 32'd0);

      // Level held high 20 cycles gives one step, S edges after first sample
      cyc(1'b0, 1'b0, 2'd0);
      for (int i = 0; i < 20; i++) begin
         cyc(1'b0, 1'b1, 2'd0);
         chk("latency_sec", 32'(sec_ones), (i < S) ? 32'd0 : 32'd1);
      end
      for (int i = 0; i <= S; i++) cyc(1'b0, 1'b0, 2'd0);
      chk("held_high_one_step", 32'(sec_ones), 32'd1);

      // 23:59:58 -> 23:59:59 -> 00:00:00 with both pulses
      ticks(2'd0, 57);
      ticks(2'd1, 59);
      ticks(2'd2, 23);
      tick_probe("to_59", 2'd0, 1'b0, 1'b0);
      tick_probe("midnight", 2'd0, 1'b1, 1'b1);
      chk("midnight_sec", 32'({sec_tens, sec_ones}), 32'd0);
      chk("midnight_min", 32'({min_tens, min_ones}), 32'd0);

      // Set minutes at 10:59:30 wraps minutes without carry
      ticks(2'd0, 30);
      ticks(2'd1, 59);
      ticks(2'd2, 10);
      tick_probe("set_min_wrap", 2'd1, 1'b0, 1'b0);
      chk("set_min_wrap_min", 32'({min_tens, min_ones}), 32'd0);
      chk("set_min_wrap_sec", 32'(sec_tens), 32'd3);

      // 23:15:07 set hours -> 00:15:07, then pause clears seconds without a tick
      cyc(1'b0, 1'b0, 2'd3);
      ticks(2'd0, 7);
      ticks(2'd1, 15);
      ticks(2'd2, 13);
      tick_probe("set_hr_wrap", 2'd2, 1'b0, 1'b0);
      chk("set_hr_wrap_sec", 32'(sec_ones), 32'd7);
      cyc(1'b0, 1'b0, 2'd3);
      chk("pause_sec", 32'({sec_tens, sec_ones}), 32'd0);
      chk("pause_min_ones", 32'(min_ones), 32'd5);

      // Reset on the same edge as a pending step discards it
      for (int i = 0; i < S; i++) cyc(1'b0, 1'b1, 2'd0);
      cyc(1'b1, 1'b1, 2'd0);
      chk("rst_step_sec", 32'(sec_ones), 32'd0);
      chk("rst_step_pulse", 32'(min_tick), 32'd0);
      for (int i = 0; i <= S + 1; i++) cyc(1'b0, 1'b1, 2'd0);
      for (int i = 0; i <= S; i++) cyc(1'b0, 1'b0, 2'd0);
      chk("post_rst_step", 32'(sec_ones), 32'd1);

`ifdef HOUR12_EN
      // 12-hour transitions across noon and midnight
      cyc(1'b1, 1'b0, 2'd0);
      chk("h12_rst_hr", 32'({hr_tens, hr_ones}), 32'h12);
      chk("h12_rst_pm", 32'(pm), 32'd0);
      ticks(2'd0, 59);
      ticks(2'd1, 59);
      ticks(2'd2, 11);
      tick_probe("noon", 2'd0, 1'b1, 1'b0);
      chk("noon_hr", 32'({hr_tens, hr_ones}), 32'h12);
      chk("noon_pm", 32'(pm), 32'd1);
      ticks(2'd0, 59);
      ticks(2'd1, 59);
      ticks(2'd2, 11);
      tick_probe("h12_midnight", 2'd0, 1'b1, 1'b1);
      chk("h12_midnight_hr", 32'({hr_tens, hr_ones}), 32'h12);
      chk("h12_midnight_pm", 32'(pm), 32'd0);
`endif

      // Randomized tick phases and per-cycle modes, occasional reset
      tk = 1'b0;
      for (int p = 0; p < 400; p++) begin
         tk  = ~tk;
         len = int'($urandom_range(S + 1, S + 4));
         for (int i = 0; i < len; i++) begin
            r  = int'($urandom_range(0, 19));
            md = (r < 12) ? 2'd0 : (r < 15) ? 2'd1 : (r < 18) ? 2'd2 : 2'd3;
            cyc(($urandom_range(0, 299) == 0), tk, md);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
